// File: rtl/hub_arb.sv
// hub_arb: round-robin hub memory scheduler, 2-clock access slots; ack + cog_q two edges after issue.
// No backpressure: cog_req is held until its ack. Define HUB_ARB_SKIP_EN to grant the next requesting cog instead of a fixed rotation.
module hub_arb #(
    parameter  int COGS = 8,
    localparam int SW   = $clog2(COGS)
) (
    input  logic               clk_cog,
    input  logic               res,
    input  logic [COGS-1:0]    cog_req,
    input  logic [COGS-1:0]    cog_w,
    input  logic [4*COGS-1:0]  cog_wb,
    input  logic [14*COGS-1:0] cog_a,
    input  logic [32*COGS-1:0] cog_d,
    output logic [COGS-1:0]    cog_ack,
    output logic [31:0]        cog_q,
    output logic [SW-1:0]      hub_slot,
    output logic               ena_bus,
    output logic               mem_w,
    output logic [3:0]         mem_wb,
    output logic [13:0]        mem_a,
    output logic [31:0]        mem_d,
    input  logic [31:0]        mem_q
);

    typedef enum logic {
        PH_ISSUE  = 1'b0,
        PH_RETIRE = 1'b1
    } ph_e;

    ph_e             ph_q, ph_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic            gnt_q, gnt_d;
    logic            pend_vld_q, pend_vld_d;
    logic [SW-1:0]   pend_cog_q, pend_cog_d;
    logic            ena_q, ena_d;
    logic            mem_w_q, mem_w_d;
    logic [3:0]      mem_wb_q, mem_wb_d;
    logic [13:0]     mem_a_q, mem_a_d;
    logic [31:0]     mem_d_q, mem_d_d;
    logic [COGS-1:0] ack_q, ack_d;
    logic [31:0]     cog_q_q, cog_q_d;

    logic [SW-1:0]   sel;
    logic            sel_vld;

`ifdef HUB_ARB_SKIP_EN
    // First requester at or after ptr, with wrap; idle slot falls back to ptr.
    always_comb begin
        logic [SW-1:0] cand;
        cand    = '0;
        sel     = ptr_q;
        sel_vld = 1'b0;
        for (int i = 0; i < COGS; i++) begin
            cand = SW'(ptr_q + SW'(i));
            if (!sel_vld && cog_req[cand]) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end
`else
    always_comb begin
        sel     = ptr_q;
        sel_vld = cog_req[ptr_q];
    end
`endif

    always_comb begin
        ph_d       = ph_q;
        ptr_d      = ptr_q;
        slot_d     = slot_q;
        gnt_d      = gnt_q;
        pend_vld_d = pend_vld_q;
        pend_cog_d = pend_cog_q;
        ena_d      = ena_q;
        mem_w_d    = mem_w_q;
        mem_wb_d   = mem_wb_q;
        mem_a_d    = mem_a_q;
        mem_d_d    = mem_d_q;
        ack_d      = '0;
        cog_q_d    = cog_q_q;

        if (ph_q == PH_ISSUE) begin
            ph_d   = PH_RETIRE;
            ena_d  = 1'b1;
            slot_d = sel;
            gnt_d  = sel_vld;
            if (sel_vld) begin
                mem_w_d  = cog_w[sel];
                mem_wb_d = cog_wb[4*sel +: 4];
                mem_a_d  = cog_a[14*sel +: 14];
                mem_d_d  = cog_d[32*sel +: 32];
            end else begin
                mem_w_d  = 1'b0;
                mem_wb_d = 4'h0;
            end
            // Data for the previous slot's access is on mem_q by now.
            if (pend_vld_q) begin
                cog_q_d            = mem_q;
                ack_d[pend_cog_q]  = 1'b1;
            end
            pend_vld_d = 1'b0;
        end else begin
            ph_d       = PH_ISSUE;
            ena_d      = 1'b0;
            ptr_d      = SW'(slot_q + SW'(1));
            pend_vld_d = gnt_q;
            pend_cog_d = slot_q;
        end
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            ph_q       <= PH_ISSUE;
            ptr_q      <= '0;
            slot_q     <= '0;
            gnt_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_cog_q <= '0;
            ena_q      <= 1'b0;
            mem_w_q    <= 1'b0;
            mem_wb_q   <= 4'h0;
            mem_a_q    <= 14'h0;
            mem_d_q    <= 32'h0;
            ack_q      <= '0;
            cog_q_q    <= 32'h0;
        end else begin
            ph_q       <= ph_d;
            ptr_q      <= ptr_d;
            slot_q     <= slot_d;
            gnt_q      <= gnt_d;
            pend_vld_q <= pend_vld_d;
            pend_cog_q <= pend_cog_d;
            ena_q      <= ena_d;
            mem_w_q    <= mem_w_d;
            mem_wb_q   <= mem_wb_d;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
            ack_q      <= ack_d;
            cog_q_q    <= cog_q_d;
        end
    end

    assign cog_ack  = ack_q;
    assign cog_q    = cog_q_q;
    assign hub_slot = slot_q;
    assign ena_bus  = ena_q;
    assign mem_w    = mem_w_q;
    assign mem_wb   = mem_wb_q;
    assign mem_a    = mem_a_q;
    assign mem_d    = mem_d_q;

endmodule

// File: tb/tb_hub_arb.sv
// Directed bench for hub_arb (COGS=8) with a read-before-write hub memory model.
module tb_hub_arb;
    localparam int COGS = 8;
    localparam int SW   = 3;

    logic               clk_cog = 1'b0;
    logic               res;
    logic [COGS-1:0]    cog_req;
    logic [COGS-1:0]    cog_w;
    logic [4*COGS-1:0]  cog_wb;
    logic [14*COGS-1:0] cog_a;
    logic [32*COGS-1:0] cog_d;
    logic [COGS-1:0]    cog_ack;
    logic [31:0]        cog_q;
    logic [SW-1:0]      hub_slot;
    logic               ena_bus;
    logic               mem_w;
    logic [3:0]         mem_wb;
    logic [13:0]        mem_a;
    logic [31:0]        mem_d;
    logic [31:0]        mem_q;

    int tests  = 0;
    int failed = 0;
    int edge_n = 0;

    logic [31:0] mem [0:16383];
    logic        pre_en = 1'b0;
    logic [13:0] pre_a  = 14'h0;
    logic [31:0] pre_d  = 32'h0;

    always #5 clk_cog = ~clk_cog;

    hub_arb #(.COGS(COGS)) dut (
        .clk_cog  (clk_cog),
        .res      (res),
        .cog_req  (cog_req),
        .cog_w    (cog_w),
        .cog_wb   (cog_wb),
        .cog_a    (cog_a),
        .cog_d    (cog_d),
        .cog_ack  (cog_ack),
        .cog_q    (cog_q),
        .hub_slot (hub_slot),
        .ena_bus  (ena_bus),
        .mem_w    (mem_w),
        .mem_wb   (mem_wb),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] wb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (wb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Hub memory: samples the port while ena_bus is high, read data valid after that edge.
    always @(posedge clk_cog) begin
        if (pre_en) begin
            mem[pre_a] <= pre_d;
        end else if (ena_bus) begin
            mem_q <= mem[mem_a];
            if (mem_w && !mem_a[13])
                mem[mem_a] <= merge(mem[mem_a], mem_d, mem_wb);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {33'b0, ena_bus, hub_slot, mem_w, mem_wb, mem_a, mem_d, cog_ack, cog_q};
    endfunction

    task automatic step();
        @(posedge clk_cog);
        #1;
        edge_n++;
    endtask

    task automatic preload(input logic [13:0] a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(posedge clk_cog);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        res     = 1'b1;
        cog_req = '0;
        cog_w   = '0;
        cog_wb  = '0;
        cog_a   = '0;
        cog_d   = '0;
        repeat (2) @(posedge clk_cog);
        #1;
        chk("reset_outputs", outs(), 128'h0);
        @(negedge clk_cog);
        res    = 1'b0;
        edge_n = 0;
    endtask

    task automatic set_cog(input int c, input logic r, input logic w, input logic [3:0] wb,
                           input logic [13:0] a, input logic [31:0] d);
        cog_req[c]         = r;
        cog_w[c]           = w;
        cog_wb[4*c +: 4]   = wb;
        cog_a[14*c +: 14]  = a;
        cog_d[32*c +: 32]  = d;
    endtask

    typedef struct {
        int          cog;
        logic        w;
        logic [3:0]  wb;
        logic [13:0] a;
        logic [31:0] d;
        logic        pre;
        logic [31:0] pre_v;
        logic [31:0] exp_q;
        logic [31:0] exp_mem;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[6];
        int   iss;
        int   k;

        res     = 1'b1;
        cog_req = '0;
        cog_w   = '0;
        cog_wb  = '0;
        cog_a   = '0;
        cog_d   = '0;

`ifdef HUB_ARB_SKIP_EN
        preload(14'h0060, 32'h66660006);
        preload(14'h0070, 32'h77770007);
        preload(14'h0001, 32'h00000101);
        do_reset();
        set_cog(6, 1'b1, 1'b0, 4'h0, 14'h0060, 32'h0);
        step();
        chk("skip_e1_ena", 128'(ena_bus), 128'd1);
        chk("skip_e1_slot", 128'(hub_slot), 128'd6);
        chk("skip_e1_a", 128'(mem_a), 128'h0060);
        set_cog(7, 1'b1, 1'b0, 4'h0, 14'h0070, 32'h0);
        set_cog(0, 1'b1, 1'b0, 4'h0, 14'h0001, 32'h0);
        step();
        chk("skip_e2_ack", 128'(cog_ack), 128'h0);
        step();
        chk("skip_e3_ack", 128'(cog_ack), 128'h40);
        chk("skip_e3_q", 128'(cog_q), 128'h66660006);
        chk("skip_e3_slot", 128'(hub_slot), 128'd7);
        cog_req[6] = 1'b0;
        step();
        chk("skip_e4_ack", 128'(cog_ack), 128'h0);
        step();
        chk("skip_e5_ack", 128'(cog_ack), 128'h80);
        chk("skip_e5_q", 128'(cog_q), 128'h77770007);
        chk("skip_e5_slot", 128'(hub_slot), 128'd0);
        cog_req[7] = 1'b0;
        step();
        step();
        chk("skip_e7_ack", 128'(cog_ack), 128'h01);
        chk("skip_e7_q", 128'(cog_q), 128'h00000101);
        cog_req[0] = 1'b0;
`else
        // Single-cog transactions from reset; issue at edge 2*cog+1, ack two edges later.
        vecs[0] = '{0, 1'b0, 4'h0, 14'h0010, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{5, 1'b0, 4'h0, 14'h0123, 32'h0,        1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[2] = '{2, 1'b1, 4'h3, 14'h0100, 32'h12345678, 1'b1, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABB5678};
        vecs[3] = '{7, 1'b1, 4'hF, 14'h2005, 32'hFFFFFFFF, 1'b1, 32'h0BADC0DE, 32'h0BADC0DE, 32'h0BADC0DE};
        vecs[4] = '{3, 1'b0, 4'h0, 14'h3FFF, 32'h0,        1'b1, 32'h13579BDF, 32'h13579BDF, 32'h13579BDF};
        vecs[5] = '{2, 1'b0, 4'h0, 14'h0100, 32'h0,        1'b0, 32'h0,        32'hAABB5678, 32'hAABB5678};

        for (int v = 0; v < 6; v++) begin
            res = 1'b1;
            if (vecs[v].pre) preload(vecs[v].a, vecs[v].pre_v);
            do_reset();
            iss = 2 * vecs[v].cog + 1;
            set_cog(vecs[v].cog, 1'b1, vecs[v].w, vecs[v].wb, vecs[v].a, vecs[v].d);
            for (int e = 1; e <= iss + 3; e++) begin
                step();
                if (e == iss) begin
                    chk("issue_ena", 128'(ena_bus), 128'd1);
                    chk("issue_slot", 128'(hub_slot), 128'(vecs[v].cog));
                    chk("issue_a", 128'(mem_a), 128'(vecs[v].a));
                    chk("issue_w", 128'(mem_w), 128'(vecs[v].w));
                    chk("issue_wb", 128'(mem_wb), 128'(vecs[v].wb));
                    if (vecs[v].w) chk("issue_d", 128'(mem_d), 128'(vecs[v].d));
                    // Late field changes must not reach the memory port.
                    cog_a[14*vecs[v].cog +: 14] = ~vecs[v].a;
                    cog_d[32*vecs[v].cog +: 32] = ~vecs[v].d;
                end
                if (e == iss + 1) begin
                    chk("retire_ena", 128'(ena_bus), 128'd0);
                    chk("retire_a_hold", 128'(mem_a), 128'(vecs[v].a));
                end
                if (e == iss + 2) begin
                    chk("ack", 128'(cog_ack), 128'd1 << vecs[v].cog);
                    chk("ack_q", 128'(cog_q), 128'(vecs[v].exp_q));
                    chk("idle_w", 128'({mem_w, mem_wb}), 128'h0);
                    cog_req[vecs[v].cog] = 1'b0;
                end else begin
                    chk("no_ack", 128'(cog_ack), 128'h0);
                end
                if (e == iss + 3) chk("q_hold", 128'(cog_q), 128'(vecs[v].exp_q));
            end
            chk("mem_after", 128'(mem[vecs[v].a]), 128'(vecs[v].exp_mem));
        end

        // All cogs requesting continuously: acks in order, one every two clocks.
        res = 1'b1;
        for (int i = 0; i < COGS; i++) preload(14'(32'h200 + i), 32'hA0000000 + i);
        do_reset();
        for (int i = 0; i < COGS; i++) set_cog(i, 1'b1, 1'b0, 4'h0, 14'(32'h200 + i), 32'h0);
        for (int e = 1; e <= 36; e++) begin
            step();
            if (e % 2 == 1) begin
                chk("rr_slot", 128'(hub_slot), 128'(((e - 1) / 2) % 8));
                if (e >= 3) begin
                    k = ((e - 3) / 2) % 8;
                    chk("rr_ack", 128'(cog_ack), 128'd1 << k);
                    chk("rr_q", 128'(cog_q), 128'(32'hA0000000 + k));
                end else begin
                    chk("rr_ack_first", 128'(cog_ack), 128'h0);
                end
            end else begin
                chk("rr_ack_clr", 128'(cog_ack), 128'h0);
            end
        end
        cog_req = '0;

        // Reset between issue and ack of a cog0 read.
        res = 1'b1;
        preload(14'h0010, 32'hDEADBEEF);
        do_reset();
        set_cog(0, 1'b1, 1'b0, 4'h0, 14'h0010, 32'h0);
        step();
        chk("mr_e1_ena", 128'(ena_bus), 128'd1);
        step();
        res = 1'b1;
        #1;
        chk("mr_outputs", outs(), 128'h0);
        repeat (3) begin
            @(posedge clk_cog);
            #1;
            chk("mr_noack", 128'(cog_ack), 128'h0);
        end
        @(negedge clk_cog);
        res    = 1'b0;
        edge_n = 0;
        step();
        chk("mr_reissue_slot", 128'(hub_slot), 128'd0);
        chk("mr_reissue_a", 128'({ena_bus, mem_a}), 128'({1'b1, 14'h0010}));
        step();
        chk("mr_e2_ack", 128'(cog_ack), 128'h0);
        step();
        chk("mr_e3_ack", 128'(cog_ack), 128'h01);
        chk("mr_e3_q", 128'(cog_q), 128'hDEADBEEF);
        cog_req[0] = 1'b0;

        // Cog1 asserts after its slot's issue edge: waits a full rotation.
        res = 1'b1;
        preload(14'h0042, 32'h0F0F1234);
        do_reset();
        for (int e = 1; e <= 3; e++) begin
            step();
            chk("late_pre_ack", 128'(cog_ack), 128'h0);
        end
        set_cog(1, 1'b1, 1'b0, 4'h0, 14'h0042, 32'h0);
        iss = 19;
        for (int e = 4; e <= iss + 2; e++) begin
            step();
            if (e == iss) begin
                chk("late_slot", 128'(hub_slot), 128'd1);
                chk("late_a", 128'(mem_a), 128'h0042);
                cog_a[14 +: 14] = 14'h3333;
            end
            if (e == iss + 1) chk("late_a_hold", 128'(mem_a), 128'h0042);
            if (e == iss + 2) begin
                chk("late_ack", 128'(cog_ack), 128'h02);
                chk("late_q", 128'(cog_q), 128'h0F0F1234);
                cog_req[1] = 1'b0;
            end else begin
                chk("late_no_ack", 128'(cog_ack), 128'h0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
